// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port sync RAM between bus port 0 (fixed priority) and core port 1,
//           with a starvation guard that forces a port 1 grant after MAX_WAIT consecutive denials.
// Latency : grant is combinational (0 cycles); rvalid/rdata follow one cycle after the grant.
// Backpressure: a requester holds req and fields until gnt; the denied port simply waits.
//
// Ports:
//   clk, rst                  - clock (rising edge), synchronous active-high reset
//   p0_* / p1_*               - req/addr/we/be/wdata in, gnt/rvalid/rdata out (port 0 = bus, port 1 = core)
//   ram_en/addr/we/be/wdata_o - single-port RAM command, driven from the granted port
//   ram_rdata_i               - RAM read data, valid one cycle after ram_en_o
//   starve_o                  - high while the guard is forcing port 1

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    output logic                    starve_o
);

    // A zero-width counter is not legal, so MAX_WAIT = 0 still gets one bit (it never leaves 0).
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    typedef enum logic {
        IDLE_PRIO = 1'b0,
        FORCED    = 1'b1
    } guard_state_t;

    guard_state_t  guard_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nxt;
    logic          pend_valid;
    logic          pend_owner;
    logic          force_p1;

    // guard_state is registered alongside wait_cnt and is FORCED exactly when wait_cnt has
    // reached the limit, so the force decision comes straight from a flop.
    assign force_p1 = (guard_state == FORCED) && !rst;
    assign starve_o = force_p1;

    assign p0_gnt_o = !rst && p0_req_i && !(force_p1 && p1_req_i);
    assign p1_gnt_o = !rst && p1_req_i && !p0_gnt_o;
    assign ram_en_o = p0_gnt_o | p1_gnt_o;

    // The wait budget only counts an unbroken run of denied port 1 requests.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!p1_req_i || p1_gnt_o) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + CW'(1);
        end
    end

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (p0_gnt_o) begin
            ram_addr_o  = p0_addr_i;
            ram_we_o    = p0_we_i;
            ram_be_o    = p0_be_i;
            ram_wdata_o = p0_wdata_i;
        end else if (p1_gnt_o) begin
            ram_addr_o  = p1_addr_i;
            ram_we_o    = p1_we_i;
            ram_be_o    = p1_be_i;
            ram_wdata_o = p1_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            guard_state <= IDLE_PRIO;
            pend_valid  <= 1'b0;
            pend_owner  <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            guard_state <= ((MAX_WAIT != 0) && (wait_cnt_nxt == WAIT_LIMIT)) ? FORCED : IDLE_PRIO;
            pend_valid  <= ram_en_o;
            pend_owner  <= p1_gnt_o;
        end
    end

    // Responses are returned for writes too; rdata is zeroed whenever the port has no response.
    assign p0_rvalid_o = pend_valid && !pend_owner;
    assign p1_rvalid_o = pend_valid &&  pend_owner;
    assign p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            stamp;
        logic          we;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [BW-1:0] p0_be_i, p1_be_i;
    logic [DW-1:0] p0_wdata_i, p1_wdata_i;
    logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic          ram_en_o, ram_we_o, starve_o;
    logic [AW-1:0] ram_addr_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .starve_o(starve_o)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return {8'hA5, 8'(a), 8'h5A, 8'(a) ^ 8'hFF};
    endfunction

    // Environment RAM: one-cycle read latency, byte-enabled writes.
    logic [DW-1:0] ram_mem [32];
    logic          ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o[4:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end
            ram_rdata_i <= ram_mem[ram_addr_o[4:0]];
        end
    end

    // Scoreboard state and reference model
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] model_mem [32];
    int            wcnt = 0;
    resp_t         expq [2][$];
    txn_t          dq0 [$];
    txn_t          dq1 [$];
    txn_t          cur [2];
    bit            act [2];
    int            pct0 = 0, pct1 = 0;
    bit            p1_off = 0;
    logic          last_g1;
    int            g1_count;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
        errors++;
        $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.addr  = AW'($urandom_range(0, 31));
        t.we    = 1'($urandom_range(0, 1));
        t.be    = BW'($urandom_range(1, 15));
        t.wdata = $urandom;
        return t;
    endfunction

    // One clock cycle: drive at posedge+1, predict and compare at negedge.
    task automatic step(input logic r);
        bit   r0, r1, forced, eg0, eg1, est;
        txn_t g;
        int   p;
        @(posedge clk);
        #1;
        rst = r;
        if (!act[0]) begin
            if (dq0.size() > 0) begin cur[0] = dq0.pop_front(); act[0] = 1; end
            else if ($urandom_range(0, 99) < pct0) begin cur[0] = rand_txn(); act[0] = 1; end
        end
        if (!act[1]) begin
            if (dq1.size() > 0) begin cur[1] = dq1.pop_front(); act[1] = 1; end
            else if ($urandom_range(0, 99) < pct1) begin cur[1] = rand_txn(); act[1] = 1; end
        end
        // Idle ports present junk fields so stray muxing shows up on the RAM side.
        g = act[0] ? cur[0] : rand_txn();
        p0_req_i = act[0]; p0_addr_i = g.addr; p0_we_i = g.we; p0_be_i = g.be; p0_wdata_i = g.wdata;
        g = act[1] ? cur[1] : rand_txn();
        p1_req_i = act[1] && !p1_off; p1_addr_i = g.addr; p1_we_i = g.we; p1_be_i = g.be; p1_wdata_i = g.wdata;
        r0 = p0_req_i;
        r1 = p1_req_i;

        @(negedge clk);
        forced = (MW != 0) && (wcnt >= MW) && !r;
        est = forced;
        eg0 = !r && r0 && !(forced && r1);
        eg1 = !r && r1 && !eg0;
        checks++;
        if ({p0_gnt_o, p1_gnt_o, starve_o, ram_en_o} !== {eg0, eg1, est, eg0 | eg1})
            fail("gnt/starve/en", 64'({p0_gnt_o, p1_gnt_o, starve_o, ram_en_o}), 64'({eg0, eg1, est, eg0 | eg1}));
        last_g1 = p1_gnt_o;

        if (eg0 || eg1) begin
            p = eg1 ? 1 : 0;
            g = cur[p];
        end else begin
            p = 0;
            g.addr = '0; g.we = 1'b0; g.be = '0; g.wdata = '0;
        end
        checks++;
        if ({ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o} !== {g.addr, g.we, g.be, g.wdata})
            fail("ram_cmd", 64'({ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o}), 64'({g.addr, g.we, g.be, g.wdata}));

        if (eg0 || eg1) begin
            resp_t e;
            e.stamp = cyc;
            e.we    = g.we;
            e.data  = model_mem[g.addr[4:0]];
            if (g.we)
                for (int b = 0; b < BW; b++)
                    if (g.be[b]) model_mem[g.addr[4:0]][8*b +: 8] = g.wdata[8*b +: 8];
            expq[p].push_back(e);
            act[p] = 0;
        end

        if (r || !r1 || eg1) wcnt = 0;
        else if (wcnt < MW) wcnt = wcnt + 1;
    endtask

    // Response monitor: pops the expected entry whenever a port presents rvalid.
    always @(negedge clk) begin
        logic          rv;
        logic [DW-1:0] rd;
        resp_t         e;
        for (int p = 0; p < 2; p++) begin
            rv = (p == 1) ? p1_rvalid_o : p0_rvalid_o;
            rd = (p == 1) ? p1_rdata_o  : p0_rdata_o;
            while (expq[p].size() > 0 && expq[p][0].stamp < cyc - 1) begin
                checks++;
                fail(p ? "p1_missing_rvalid" : "p0_missing_rvalid", 64'(0), 64'(1));
                void'(expq[p].pop_front());
            end
            checks++;
            if (rv) begin
                if (expq[p].size() > 0 && expq[p][0].stamp == cyc - 1) begin
                    e = expq[p].pop_front();
                    if (!e.we) begin
                        checks++;
                        if (rd !== e.data) fail(p ? "p1_rdata" : "p0_rdata", 64'(rd), 64'(e.data));
                    end
                end else begin
                    fail(p ? "p1_unexpected_rvalid" : "p0_unexpected_rvalid", 64'(1), 64'(0));
                end
            end else if (rd !== '0) begin
                fail(p ? "p1_rdata_idle" : "p0_rdata_idle", 64'(rd), 64'(0));
            end
        end
    end

    task automatic drain();
        pct0 = 0; pct1 = 0; p1_off = 0;
        for (int i = 0; i < 20 && (act[0] || act[1]); i++) step(1'b0);
        checks++;
        if (act[0] || act[1]) fail("drain_timeout", 64'({act[0], act[1]}), 64'(0));
        step(1'b0);
    endtask

    initial begin
        txn_t t;
        int   k;
        rst = 1'b1;
        p0_req_i = 0; p0_addr_i = '0; p0_we_i = 0; p0_be_i = '0; p0_wdata_i = '0;
        p1_req_i = 0; p1_addr_i = '0; p1_we_i = 0; p1_be_i = '0; p1_wdata_i = '0;
        act[0] = 0; act[1] = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);

        // Reset held 3 cycles with both requesting, then port 0 wins on release.
        pct0 = 100; pct1 = 100;
        repeat (3) step(1'b1);
        step(1'b0);
        drain();

        // Port 0 read of 0x10.
        t.addr = 15'h10; t.we = 0; t.be = 4'hF; t.wdata = '0;
        dq0.push_back(t);
        step(1'b0);
        drain();

        // Contention from a cleared counter: 20 cycles -> port 1 forced 4 times.
        pct0 = 100; pct1 = 100; g1_count = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (last_g1) g1_count++;
        end
        checks++;
        if (g1_count != 4) fail("contention_p1_grants", 64'(g1_count), 64'(4));
        drain();

        // Port 1 partial write then port 0 readback.
        t.addr = 15'h4; t.we = 1; t.be = 4'b0011; t.wdata = 32'h12345678;
        dq1.push_back(t);
        step(1'b0);
        t.we = 0; t.be = 4'hF; t.wdata = '0;
        dq0.push_back(t);
        step(1'b0);
        drain();

        // Counter clears on a req gap: 3 denied, 1 off, then 4 more denials before the force.
        t.addr = 15'h7; t.we = 0; t.be = 4'hF; t.wdata = '0;
        dq1.push_back(t);
        pct0 = 100;
        repeat (3) step(1'b0);
        p1_off = 1;
        step(1'b0);
        p1_off = 0;
        k = -1;
        for (int i = 0; i < 10 && k < 0; i++) begin
            step(1'b0);
            if (last_g1) k = i;
        end
        checks++;
        if (k != 4) fail("req_gap_force_index", 64'(k), 64'(4));
        drain();

        // Reset in the cycle port 1 requests: no grant, no response.
        t.addr = 15'h9; t.we = 0;
        dq1.push_back(t);
        step(1'b1);
        step(1'b0);
        drain();

        // Randomized traffic with occasional resets and port 1 req gaps.
        for (int seg = 0; seg < 20; seg++) begin
            pct0 = $urandom_range(0, 100);
            pct1 = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                p1_off = ($urandom_range(0, 99) < 5);
                step($urandom_range(0, 99) < 2);
            end
        end
        drain();
        repeat (3) step(1'b0);
        checks++;
        if (expq[0].size() + expq[1].size() != 0)
            fail("leftover_responses", 64'(expq[0].size() + expq[1].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
